// File: rtl/canny_pkg.sv
// Shared constants for the Canny pipeline (Gaussian, Sobel, NMS stages):
// image geometry, pixel width and the 3x3 Gaussian kernel weights.
package canny_pkg;

  localparam int PW     = 8;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;

  // Kernel [1 2 1; 2 4 2; 1 2 1] / 16 is separable: row weights times column weights.
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;
  localparam int NORM_SH  = 4;
  localparam int ROUND    = 8;

  // Per-pixel sideband carried alongside the arithmetic pipeline.
  typedef struct packed {
    logic valid;
    logic interior;
    logic last;
  } pix_tag_t;

endpackage

// File: rtl/gaussian_row_sum.sv
// One row of the separable Gaussian kernel: a + 2b + c, purely combinational.
// Output is PW+2 bits so the maximum (4 * max pixel) never overflows.
module gaussian_row_sum #(
  parameter int PW = canny_pkg::PW
) (
  input  logic [PW-1:0] i_a,
  input  logic [PW-1:0] i_b,
  input  logic [PW-1:0] i_c,
  output logic [PW+1:0] o_sum
);
  import canny_pkg::*;

  localparam int RW = PW + 2;

  assign o_sum = RW'(K_CORNER) * RW'(i_a)
               + RW'(K_EDGE)   * RW'(i_b)
               + RW'(K_CORNER) * RW'(i_c);

endmodule

// File: rtl/gaussian_3x3_filter.sv
// Canny stage 1: 3x3 Gaussian smoothing over line-buffer row taps.
// Window load -> S1 row sums -> S2 column sum and rounding; border pixels emit zero.
module gaussian_3x3_filter #(
  parameter int WIDTH  = canny_pkg::WIDTH,
  parameter int HEIGHT = canny_pkg::HEIGHT,
  parameter int PW     = canny_pkg::PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sof,
  input  logic          in_valid,
  input  logic [PW-1:0] row_top,
  input  logic [PW-1:0] row_mid,
  input  logic [PW-1:0] row_bot,
  output logic          out_valid,
  output logic [PW-1:0] out_pixel,
  output logic          frame_done
);
  import canny_pkg::*;

  // Stream protocol: in_valid qualifies one column of taps; there is no
  // backpressure, so each accepted column yields exactly one out_valid beat
  // three cycles later, in order, with idle cycles passing straight through.

  localparam int CW    = $clog2(WIDTH);
  localparam int RWD   = $clog2(HEIGHT);
  localparam int RS_W  = PW + 2;
  localparam int SUM_W = PW + 4;
  localparam int MID_W = K_CENTRE / K_EDGE;

  logic [PW-1:0]   r_win_t [3];
  logic [PW-1:0]   r_win_m [3];
  logic [PW-1:0]   r_win_b [3];
  logic [CW-1:0]   r_col;
  logic [RWD-1:0]  r_row;
  pix_tag_t        r_tag0;
  pix_tag_t        r_tag1;
  logic [RS_W-1:0] r_rs_t;
  logic [RS_W-1:0] r_rs_m;
  logic [RS_W-1:0] r_rs_b;

  logic [CW-1:0]    w_col_pos;
  logic [RWD-1:0]   w_row_pos;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_interior;
  logic             w_last;
  logic             w_early_sof;
  logic [RS_W-1:0]  w_rs_t;
  logic [RS_W-1:0]  w_rs_m;
  logic [RS_W-1:0]  w_rs_b;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_rnd;
  logic [PW-1:0]    w_pix;

  // Position of the pixel being accepted; sof overrides whatever the counters hold.
  always_comb begin
    w_col_pos   = sof ? '0 : r_col;
    w_row_pos   = sof ? '0 : r_row;
    w_col_end   = (w_col_pos == CW'(WIDTH - 1));
    w_row_end   = (w_row_pos == RWD'(HEIGHT - 1));
    w_interior  = (w_col_pos >= CW'(2)) && (w_row_pos >= RWD'(2));
    w_last      = w_col_end && w_row_end;
    w_early_sof = sof && in_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r_win_t[i] <= '0;
        r_win_m[i] <= '0;
        r_win_b[i] <= '0;
      end
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      r_win_t[0] <= r_win_t[1];
      r_win_t[1] <= r_win_t[2];
      r_win_t[2] <= row_top;
      r_win_m[0] <= r_win_m[1];
      r_win_m[1] <= r_win_m[2];
      r_win_m[2] <= row_mid;
      r_win_b[0] <= r_win_b[1];
      r_win_b[1] <= r_win_b[2];
      r_win_b[2] <= row_bot;
      r_col      <= w_col_end ? '0 : w_col_pos + CW'(1);
      if (w_col_end) begin
        r_row <= w_row_end ? '0 : w_row_pos + RWD'(1);
      end else begin
        r_row <= w_row_pos;
      end
    end
  end

  gaussian_row_sum #(.PW(PW)) u_rs_top (
    .i_a(r_win_t[0]), .i_b(r_win_t[1]), .i_c(r_win_t[2]), .o_sum(w_rs_t)
  );
  gaussian_row_sum #(.PW(PW)) u_rs_mid (
    .i_a(r_win_m[0]), .i_b(r_win_m[1]), .i_c(r_win_m[2]), .o_sum(w_rs_m)
  );
  gaussian_row_sum #(.PW(PW)) u_rs_bot (
    .i_a(r_win_b[0]), .i_b(r_win_b[1]), .i_c(r_win_b[2]), .o_sum(w_rs_b)
  );

  // An early sof closes the previous frame: its youngest in-flight pixel
  // (still in the window stage or in S1) picks up the last tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag0 <= '0;
      r_tag1 <= '0;
      r_rs_t <= '0;
      r_rs_m <= '0;
      r_rs_b <= '0;
    end else begin
      r_tag0.valid    <= in_valid;
      r_tag0.interior <= w_interior;
      r_tag0.last     <= w_last;
      r_tag1.valid    <= r_tag0.valid;
      r_tag1.interior <= r_tag0.interior;
      r_tag1.last     <= r_tag0.last || (w_early_sof && r_tag0.valid);
      if (r_tag0.valid) begin
        r_rs_t <= w_rs_t;
        r_rs_m <= w_rs_m;
        r_rs_b <= w_rs_b;
      end
    end
  end

  always_comb begin
    w_sum = SUM_W'(r_rs_t) + SUM_W'(MID_W) * SUM_W'(r_rs_m) + SUM_W'(r_rs_b);
    w_rnd = w_sum + SUM_W'(ROUND);
    w_pix = PW'(w_rnd >> NORM_SH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= r_tag1.valid;
      frame_done <= r_tag1.valid &&
                    (r_tag1.last || (w_early_sof && !r_tag0.valid));
      if (r_tag1.valid) begin
        out_pixel <= r_tag1.interior ? w_pix : '0;
      end
    end
  end

endmodule

// File: tb/tb_gaussian_3x3_filter.sv
// Bench for gaussian_3x3_filter: drives images built in an array, predicts each
// output from the 3x3 kernel applied to that array, and checks value, cycle and frame_done.
module tb_gaussian_3x3_filter;

  localparam int W = 320;
  localparam int H = 240;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sof = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] row_top = '0;
  logic [7:0] row_mid = '0;
  logic [7:0] row_bot = '0;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       frame_done;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  pix;
    logic        done;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        obs_q[$];
  logic [7:0]  img [H][W];
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;
  int          stray_done = 0;

  gaussian_3x3_filter dut (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
    .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
    .out_valid(out_valid), .out_pixel(out_pixel), .frame_done(frame_done)
  );

  // clock / cycle count / output monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  always @(negedge clk) begin
    ent_t e;
    if (out_valid) begin
      e.cyc  = cyc;
      e.pix  = out_pixel;
      e.done = frame_done;
      obs_q.push_back(e);
    end else if (frame_done) begin
      stray_done <= stray_done + 1;
    end
  end

  // reference: kernel [1 2 1;2 4 2;1 2 1]/16 rounded half up, zero on border
  function automatic logic [7:0] model_pix(input int r, input int c);
    int acc;
    acc = 0;
    if (r < 2 || c < 2) return 8'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * int'(img[r-2+i][c-2+j]);
    return 8'((acc + 8) / 16);
  endfunction

  task automatic fill_img(input int mode, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? 8'(val) : 8'($urandom);
  endtask

  // one accepted column; rows above the image top get junk that must be masked
  task automatic drive_px(input int r, input int c, input logic s);
    ent_t        e;
    logic [31:0] k;
    sof      = s;
    in_valid = 1'b1;
    row_bot  = img[r][c];
    row_mid  = (r >= 1) ? img[r-1][c] : 8'($urandom);
    row_top  = (r >= 2) ? img[r-2][c] : 8'($urandom);
    @(posedge clk);
    k = cyc;
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
    row_top  = 8'($urandom);
    row_mid  = 8'($urandom);
    row_bot  = 8'($urandom);
    e.cyc  = k + 32'd3;
    e.pix  = model_pix(r, c);
    e.done = (r == H - 1) && (c == W - 1);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    repeat (6) begin
      in_valid = 1'b1;
      sof      = 1'($urandom_range(1));
      row_top  = 8'($urandom);
      row_mid  = 8'($urandom);
      row_bot  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (out_pixel !== 8'd0) begin bad++; $display("FAIL reset_pixel: got %0d want 0", out_pixel); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    in_valid = 1'b0;
    sof      = 1'b0;
    rst      = 1'b1;
    idle(4);
    total++;
    if (obs_q.size() !== 0) begin bad++; $display("FAIL reset_quiet: got %0d outputs want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  // full frame with no sof: relies on reset leaving the counters at (0,0)
  task automatic test_flat();
    int nbad, first, n, dn;
    fill_img(0, 100);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_px(r, c, 1'b0);
    idle(6);
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL flat_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1; dn = 0;
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].done) dn++;
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    end
    total++;
    if (nbad !== 0) begin
      bad++;
      $display("FAIL flat_stream: %0d differ, first #%0d got cyc=%0d pix=%0d done=%0d want cyc=%0d pix=%0d done=%0d",
               nbad, first, obs_q[first].cyc, obs_q[first].pix, obs_q[first].done,
               exp_q[first].cyc, exp_q[first].pix, exp_q[first].done);
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL flat_done_count: got %0d want 1", dn); end
    total++;
    if (obs_q[2*W+2].pix !== 8'd100) begin bad++; $display("FAIL flat_interior: got %0d want 100", obs_q[2*W+2].pix); end
    total++;
    if (obs_q[W+5].pix !== 8'd0) begin bad++; $display("FAIL flat_border: got %0d want 0", obs_q[W+5].pix); end
    total++;
    if (stray_done !== 0) begin bad++; $display("FAIL flat_stray_done: got %0d want 0", stray_done); end
    obs_q.delete(); exp_q.delete();
    pulse_reset();
  endtask

  task automatic test_impulse();
    int nbad, first, n;
    fill_img(0, 0);
    img[10][10] = 8'd255;
    img[4][20]  = 8'd6;
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < W; c++)
        drive_px(r, c, (r == 0 && c == 0));
    idle(6);
    total++;
    if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL imp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    total++;
    if (nbad !== 0) begin
      bad++;
      $display("FAIL imp_stream: %0d differ, first #%0d got pix=%0d done=%0d want pix=%0d done=%0d",
               nbad, first, obs_q[first].pix, obs_q[first].done, exp_q[first].pix, exp_q[first].done);
    end
    // output centred at (r,c) leaves with input pixel (r+1,c+1)
    total++;
    if (obs_q[10*W+10].pix !== 8'd16) begin bad++; $display("FAIL imp_corner: got %0d want 16", obs_q[10*W+10].pix); end
    total++;
    if (obs_q[10*W+11].pix !== 8'd32) begin bad++; $display("FAIL imp_edge: got %0d want 32", obs_q[10*W+11].pix); end
    total++;
    if (obs_q[11*W+11].pix !== 8'd64) begin bad++; $display("FAIL imp_centre: got %0d want 64", obs_q[11*W+11].pix); end
    total++;
    if (obs_q[5*W+21].pix !== 8'd2) begin bad++; $display("FAIL round_24: got %0d want 2", obs_q[5*W+21].pix); end
    obs_q.delete(); exp_q.delete();
    pulse_reset();
  endtask

  task automatic test_max();
    int nbad, first, n;
    fill_img(0, 255);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        drive_px(r, c, (r == 0 && c == 0));
    idle(6);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    total++;
    if (nbad !== 0 || obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL max_stream: %0d differ, sizes got %0d want %0d", nbad, obs_q.size(), exp_q.size());
    end
    total++;
    if (obs_q[2*W+7].pix !== 8'd255) begin bad++; $display("FAIL max_interior: got %0d want 255", obs_q[2*W+7].pix); end
    obs_q.delete(); exp_q.delete();
    pulse_reset();
  endtask

  task automatic test_stall();
    int nbad, first, n;
    fill_img(1, 0);
    drive_px(0, 0, 1'b1);
    idle(2);
    drive_px(0, 1, 1'b0);
    drive_px(0, 2, 1'b0);
    for (int k = 3; k < 3*W; k++) begin
      if ($urandom_range(99) < 30) idle($urandom_range(3, 1));
      drive_px(k / W, k % W, 1'b0);
    end
    idle(6);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    total++;
    if (nbad !== 0 || obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL stall_stream: %0d differ, sizes got %0d want %0d", nbad, obs_q.size(), exp_q.size());
    end
    total++;
    if (obs_q[1].cyc - obs_q[0].cyc !== 32'd3) begin bad++; $display("FAIL stall_gap: got %0d want 3", obs_q[1].cyc - obs_q[0].cyc); end
    total++;
    if (obs_q[2].cyc - obs_q[1].cyc !== 32'd1) begin bad++; $display("FAIL stall_b2b: got %0d want 1", obs_q[2].cyc - obs_q[1].cyc); end
    obs_q.delete(); exp_q.delete();
    pulse_reset();
  endtask

  task automatic test_early_sof_reset();
    int nbad, first, n;
    fill_img(1, 0);
    for (int k = 0; k < 1000; k++) drive_px(k / W, k % W, (k == 0));
    // the next pixel carries sof, so pixel 1000 ends a truncated frame
    exp_q[exp_q.size()-1].done = 1'b1;
    fill_img(1, 0);
    for (int k = 0; k < 500; k++) drive_px(k / W, k % W, (k == 0));
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_pixel !== 8'd0) begin
      bad++;
      $display("FAIL async_cut: got valid=%b pix=%0d want valid=0 pix=0", out_valid, out_pixel);
    end
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc - 32'd1) void'(exp_q.pop_back());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    total++;
    if (nbad !== 0 || obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL early_stream: %0d differ, sizes got %0d want %0d", nbad, obs_q.size(), exp_q.size());
    end
    total++;
    if (obs_q[999].done !== 1'b1) begin bad++; $display("FAIL early_done: got %b want 1", obs_q[999].done); end
    obs_q.delete(); exp_q.delete();
    idle(2);
    rst = 1'b1;
    idle(1);
    fill_img(1, 0);
    for (int k = 0; k < 3*W; k++) drive_px(k / W, k % W, 1'b0);
    idle(6);
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    nbad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) begin nbad++; if (first < 0) first = i; end
    total++;
    if (nbad !== 0 || obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL post_reset_stream: %0d differ, sizes got %0d want %0d", nbad, obs_q.size(), exp_q.size());
    end
    total++;
    if (stray_done !== 0) begin bad++; $display("FAIL stray_done: got %0d want 0", stray_done); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_flat();
    test_impulse();
    test_max();
    test_stall();
    test_early_sof_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
